sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Purpose:
//   Shares one asynchronous-style SRAM between two requesters: the CPU
//   port and a debug/loader (DBG) port. A request seen while idle is
//   latched and serviced as one SRAM access lasting WAIT_CYC+1 cycles,
//   followed by a one-cycle completion pulse on the granted port.
//
// Parameters:
//   ADDR_W   SRAM address width
//   DATA_W   SRAM data width
//   WAIT_CYC extra SRAM access cycles beyond the first (0..15)
//
// Ports:
//   Clk, Reset                    clock, synchronous active-high reset
//   CPU_Req/WE/Addr/WData         CPU request, type, address, write data
//   CPU_RData, CPU_Ack            CPU read data, completion pulse
//   DBG_Req/WE/Addr/WData         debug request, type, address, write data
//   DBG_RData, DBG_Ack            debug read data, completion pulse
//   Mem_OE, Mem_WE                SRAM output / write enable
//   Mem_Addr, Mem_WData           SRAM address / write data
//   Mem_RData                     SRAM read data
//   Busy                          high whenever the FSM is not idle
//   Fsm_State                     current FSM state (debug visibility)
//
// Handshake:
//   Req is a level held by the requester until its Ack. Ack is a single
//   cycle pulse; RData is valid while Ack is high and holds afterwards
//   until the next read on that port completes. Req is only sampled in
//   IDLE, so a Req still high after Ack starts a new access.
//
// Optional feature:
//   Define MEM_ARB_RR_EN to resolve simultaneous requests round-robin
//   (the port not granted most recently wins). Without it the CPU wins
//   every tie and no last-grant state exists.
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  // CPU port
  input  logic              CPU_Req,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_Addr,
  input  logic [DATA_W-1:0] CPU_WData,
  output logic [DATA_W-1:0] CPU_RData,
  output logic              CPU_Ack,
  // Debug / loader port
  input  logic              DBG_Req,
  input  logic              DBG_WE,
  input  logic [ADDR_W-1:0] DBG_Addr,
  input  logic [DATA_W-1:0] DBG_WData,
  output logic [DATA_W-1:0] DBG_RData,
  output logic              DBG_Ack,
  // SRAM side
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  // Status
  output logic              Busy,
  output logic [1:0]        Fsm_State
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Counter load value; the counter is 4 bits wide to cover 0..15.
  localparam logic [3:0] WAIT_LD = WAIT_CYC[3:0];

  state_t            state;
  logic [3:0]        cnt;
  logic              gnt_dbg;     // 1 = current access belongs to DBG
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              pick_dbg;    // arbitration result for this cycle
  logic              any_req;

`ifdef MEM_ARB_RR_EN
  logic              last_dbg;    // 1 = most recent grant went to DBG
`endif

  assign any_req = CPU_Req | DBG_Req;

  // Arbitration: a lone request wins outright; a tie is fixed-priority
  // CPU, or goes to the port that did not win last time in RR builds.
  always_comb begin
    pick_dbg = 1'b0;
    if (DBG_Req && !CPU_Req) begin
      pick_dbg = 1'b1;
    end else if (DBG_Req && CPU_Req) begin
`ifdef MEM_ARB_RR_EN
      pick_dbg = ~last_dbg;
`else
      pick_dbg = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      gnt_dbg     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      Mem_OE      <= 1'b0;
      Mem_WE      <= 1'b0;
      CPU_Ack     <= 1'b0;
      DBG_Ack     <= 1'b0;
      Busy        <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_dbg    <= 1'b1;
`endif
    end else begin
      // Acks are single-cycle pulses; only the ACCESS->DONE step sets one.
      CPU_Ack <= 1'b0;
      DBG_Ack <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_dbg <= pick_dbg;
            we_q    <= pick_dbg ? DBG_WE    : CPU_WE;
            addr_q  <= pick_dbg ? DBG_Addr  : CPU_Addr;
            wdata_q <= pick_dbg ? DBG_WData : CPU_WData;
            cnt     <= WAIT_LD;
            // Enables are registered so they are high exactly while in ACCESS.
            Mem_OE  <= pick_dbg ? ~DBG_WE : ~CPU_WE;
            Mem_WE  <= pick_dbg ?  DBG_WE :  CPU_WE;
            Busy    <= 1'b1;
            state   <= ACCESS;
`ifdef MEM_ARB_RR_EN
            last_dbg <= pick_dbg;
`endif
          end
        end

        ACCESS: begin
          if (cnt == 4'd0) begin
            // Last access cycle: SRAM data has settled, capture it for reads.
            if (!we_q) begin
              if (gnt_dbg) dbg_rdata_q <= Mem_RData;
              else         cpu_rdata_q <= Mem_RData;
            end
            Mem_OE  <= 1'b0;
            Mem_WE  <= 1'b0;
            CPU_Ack <= ~gnt_dbg;
            DBG_Ack <=  gnt_dbg;
            state   <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          // Unused encoding: fall back to a quiet idle.
          Mem_OE <= 1'b0;
          Mem_WE <= 1'b0;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Address/data come straight from the latched registers, which only
  // change at a grant, so they hold their last values while idle.
  assign Mem_Addr  = addr_q;
  assign Mem_WData = wdata_q;
  assign CPU_RData = cpu_rdata_q;
  assign DBG_RData = dbg_rdata_q;
  assign Fsm_State = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//
// Bench for sram_arbiter. A main instance (default parameters) talks to a
// small SRAM model; two extra instances cover WAIT_CYC=0 and WAIT_CYC=15.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int WAIT = 2;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  // ---------------- main DUT signals ----------------
  logic        CPU_Req = 0, CPU_WE = 0;
  logic [15:0] CPU_Addr = 0, CPU_WData = 0;
  logic [15:0] CPU_RData;
  logic        CPU_Ack;
  logic        DBG_Req = 0, DBG_WE = 0;
  logic [15:0] DBG_Addr = 0, DBG_WData = 0;
  logic [15:0] DBG_RData;
  logic        DBG_Ack;
  logic        Mem_OE, Mem_WE;
  logic [15:0] Mem_Addr, Mem_WData, Mem_RData;
  logic        Busy;
  logic [1:0]  Fsm_State;

  // SRAM model: combinational read, write on the rising edge with WE.
  logic [15:0] mem [0:255];
  logic [15:0] shadow [0:255];
  assign Mem_RData = mem[Mem_Addr[7:0]];
  always @(posedge Clk) if (Mem_WE) mem[Mem_Addr[7:0]] <= Mem_WData;

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(WAIT)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .CPU_Req(CPU_Req), .CPU_WE(CPU_WE), .CPU_Addr(CPU_Addr), .CPU_WData(CPU_WData),
    .CPU_RData(CPU_RData), .CPU_Ack(CPU_Ack),
    .DBG_Req(DBG_Req), .DBG_WE(DBG_WE), .DBG_Addr(DBG_Addr), .DBG_WData(DBG_WData),
    .DBG_RData(DBG_RData), .DBG_Ack(DBG_Ack),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_RData(Mem_RData), .Busy(Busy), .Fsm_State(Fsm_State)
  );

  // ---------------- WAIT_CYC = 0 / 15 instances ----------------
  logic        w0_req = 0, w15_req = 0;
  logic [15:0] w0_rdata, w15_rdata, w0_drdata, w15_drdata;
  logic        w0_ack, w15_ack, w0_dack, w15_dack;
  logic        w0_oe, w15_oe, w0_we, w15_we, w0_busy, w15_busy;
  logic [15:0] w0_maddr, w15_maddr, w0_mwdata, w15_mwdata;
  logic [1:0]  w0_state, w15_state;

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(0)) u_w0 (
    .Clk(Clk), .Reset(Reset),
    .CPU_Req(w0_req), .CPU_WE(1'b0), .CPU_Addr(16'h0044), .CPU_WData(16'h0000),
    .CPU_RData(w0_rdata), .CPU_Ack(w0_ack),
    .DBG_Req(1'b0), .DBG_WE(1'b0), .DBG_Addr(16'h0000), .DBG_WData(16'h0000),
    .DBG_RData(w0_drdata), .DBG_Ack(w0_dack),
    .Mem_OE(w0_oe), .Mem_WE(w0_we), .Mem_Addr(w0_maddr), .Mem_WData(w0_mwdata),
    .Mem_RData(16'h0F0F), .Busy(w0_busy), .Fsm_State(w0_state)
  );

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(15)) u_w15 (
    .Clk(Clk), .Reset(Reset),
    .CPU_Req(w15_req), .CPU_WE(1'b0), .CPU_Addr(16'h0055), .CPU_WData(16'h0000),
    .CPU_RData(w15_rdata), .CPU_Ack(w15_ack),
    .DBG_Req(1'b0), .DBG_WE(1'b0), .DBG_Addr(16'h0000), .DBG_WData(16'h0000),
    .DBG_RData(w15_drdata), .DBG_Ack(w15_dack),
    .Mem_OE(w15_oe), .Mem_WE(w15_we), .Mem_Addr(w15_maddr), .Mem_WData(w15_mwdata),
    .Mem_RData(16'hF0F0), .Busy(w15_busy), .Fsm_State(w15_state)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver: one complete transaction on the main DUT ----
  // Drives the request, monitors the SRAM side until Ack (bounded), then
  // checks latency, enable pulse widths, bus stability and data.
  task automatic run_txn(input bit dbg, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp,
                         input string name);
    int n = 0, ack_n = 0, oe_n = 0, we_n = 0, bus_bad = 0, other_ack = 0;
    logic [15:0] e, act;
    @(negedge Clk);
    if (dbg) begin
      DBG_Req = 1; DBG_WE = we; DBG_Addr = addr; DBG_WData = wdata;
    end else begin
      CPU_Req = 1; CPU_WE = we; CPU_Addr = addr; CPU_WData = wdata;
    end
    exp_q.push_back(exp);
    while (ack_n == 0 && n < 40) begin
      @(negedge Clk);
      n++;
      if (Mem_OE) oe_n++;
      if (Mem_WE) we_n++;
      if (Mem_OE && Mem_WE) bus_bad++;
      if ((Mem_OE || Mem_WE) && Mem_Addr !== addr) bus_bad++;
      if (Mem_WE && Mem_WData !== wdata) bus_bad++;
      if (dbg ? CPU_Ack : DBG_Ack) other_ack++;
      if (dbg ? DBG_Ack : CPU_Ack) begin
        ack_n = n;
        act = we ? mem[addr[7:0]] : (dbg ? DBG_RData : CPU_RData);
      end
    end
    CPU_Req = 0; DBG_Req = 0;
    check({name, "_latency"}, ack_n, WAIT + 2);
    check({name, "_oe_cycles"}, oe_n, we ? 0 : WAIT + 1);
    check({name, "_we_cycles"}, we_n, we ? WAIT + 1 : 0);
    check({name, "_bus"}, bus_bad, 0);
    check({name, "_other_ack"}, other_ack, 0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({name, "_data"}, (ack_n != 0) ? act : 16'hxxxx, e);
    end else begin
      check({name, "_queue_empty"}, 1, 0);
    end
    @(negedge Clk);
  endtask

  typedef struct {
    bit          dbg;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;    // read data, or the value the SRAM must hold after a write
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, ack_cnt, bad;
    logic [15:0] a, d;
    bit p;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h0000;
      shadow[i] = 16'h0000;
    end
    mem[8'h10] = 16'hBEEF;
    shadow[8'h10] = 16'hBEEF;

    vecs[0] = '{dbg: 0, we: 0, addr: 16'h0010, wdata: 16'h0000, exp: 16'hBEEF};
    vecs[1] = '{dbg: 1, we: 1, addr: 16'h0020, wdata: 16'h1234, exp: 16'h1234};
    vecs[2] = '{dbg: 1, we: 0, addr: 16'h0020, wdata: 16'h0000, exp: 16'h1234};
    vecs[3] = '{dbg: 0, we: 1, addr: 16'h0030, wdata: 16'hA5A5, exp: 16'hA5A5};
    vecs[4] = '{dbg: 0, we: 0, addr: 16'h0030, wdata: 16'h0000, exp: 16'hA5A5};
    vecs[5] = '{dbg: 1, we: 0, addr: 16'h0010, wdata: 16'h0000, exp: 16'hBEEF};

    // ---- reset state ----
    repeat (3) @(negedge Clk);
    Reset = 0;
    check("rst_mem_oe", Mem_OE, 0);
    check("rst_mem_we", Mem_WE, 0);
    check("rst_acks", {CPU_Ack, DBG_Ack}, 0);
    check("rst_busy", Busy, 0);
    check("rst_state", Fsm_State, 0);
    check("rst_mem_addr", Mem_Addr, 0);
    check("rst_cpu_rdata", CPU_RData, 0);

    // ---- table-driven transactions ----
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].we) shadow[vecs[i].addr[7:0]] = vecs[i].wdata;
      run_txn(vecs[i].dbg, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
              $sformatf("vec%0d", i));
    end
    check("cpu_rdata_hold", CPU_RData, 16'hA5A5);
    check("mem_addr_idle_hold", Mem_Addr, 16'h0010);

    // ---- random write/read pairs across both ports ----
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom_range(8'h40, 8'h7F));
      d = 16'($urandom_range(0, 16'hFFFF));
      p = 1'($urandom_range(0, 1));
      shadow[a[7:0]] = d;
      run_txn(p, 1, a, d, d, $sformatf("rnd_wr%0d", i));
      run_txn(~p, 0, a, 16'h0000, shadow[a[7:0]], $sformatf("rnd_rd%0d", i));
    end

    // ---- address changed mid-access has no effect ----
    @(negedge Clk);
    CPU_Req = 1; CPU_WE = 0; CPU_Addr = 16'h0010;
    n = 0; bad = 0; ack_cnt = 0;
    while (ack_cnt == 0 && n < 40) begin
      @(negedge Clk);
      n++;
      if (n == 1) CPU_Addr = 16'h0099;
      if (Busy && Mem_Addr !== 16'h0010) bad++;
      if (CPU_Ack) ack_cnt = n;
    end
    CPU_Req = 0;
    check("midchg_addr_stable", bad, 0);
    check("midchg_latency", ack_cnt, WAIT + 2);
    check("midchg_rdata", CPU_RData, 16'hBEEF);
    @(negedge Clk);

    // ---- reset during the second ACCESS cycle aborts the access ----
    @(negedge Clk);
    CPU_Req = 1; CPU_WE = 0; CPU_Addr = 16'h0030;
    @(negedge Clk);            // ACCESS cycle 1
    @(negedge Clk);            // ACCESS cycle 2
    check("abort_in_access_oe", Mem_OE, 1);
    Reset = 1;
    @(negedge Clk);
    check("abort_mem_oe", Mem_OE, 0);
    check("abort_mem_we", Mem_WE, 0);
    check("abort_busy", Busy, 0);
    Reset = 0; CPU_Req = 0;
    ack_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (CPU_Ack || DBG_Ack) ack_cnt++;
    end
    check("abort_no_ack", ack_cnt, 0);
    check("abort_rdata_cleared", CPU_RData, 0);

    // ---- both ports held high: grant order ----
`ifdef MEM_ARB_RR_EN
    exp_q.push_back(16'd0); exp_q.push_back(16'd1);
    exp_q.push_back(16'd0); exp_q.push_back(16'd1);
`else
    exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    exp_q.push_back(16'd0); exp_q.push_back(16'd0);
`endif
    @(negedge Clk);
    CPU_Req = 1; CPU_WE = 0; CPU_Addr = 16'h0010;
    DBG_Req = 1; DBG_WE = 0; DBG_Addr = 16'h0020;
    n = 0; ack_cnt = 0; bad = 0;
    while (ack_cnt < 4 && n < 60) begin
      @(negedge Clk);
      n++;
      if (CPU_Ack && DBG_Ack) bad++;
      if (CPU_Ack || DBG_Ack) begin
        ack_cnt++;
        if (exp_q.size() > 0) begin
          d = exp_q.pop_front();
          check($sformatf("tie_grant%0d", ack_cnt), {15'd0, DBG_Ack}, d);
        end
      end
    end
    CPU_Req = 0; DBG_Req = 0;
    check("tie_grant_count", ack_cnt, 4);
    check("tie_dual_ack", bad, 0);
    exp_q.delete();
    repeat (2) @(negedge Clk);

    // ---- WAIT_CYC = 0 ----
    w0_req = 1;
    n = 0; ack_cnt = 0; bad = 0;
    while (ack_cnt == 0 && n < 40) begin
      @(negedge Clk);
      n++;
      if (w0_oe) bad++;
      if (w0_ack) ack_cnt = n;
    end
    w0_req = 0;
    check("w0_latency", ack_cnt, 2);
    check("w0_oe_cycles", bad, 1);
    check("w0_rdata", w0_rdata, 16'h0F0F);

    // ---- WAIT_CYC = 15 ----
    @(negedge Clk);
    w15_req = 1;
    n = 0; ack_cnt = 0; bad = 0;
    while (ack_cnt == 0 && n < 60) begin
      @(negedge Clk);
      n++;
      if (w15_oe) bad++;
      if (w15_ack) ack_cnt = n;
    end
    w15_req = 0;
    check("w15_latency", ack_cnt, 17);
    check("w15_oe_cycles", bad, 16);
    check("w15_rdata", w15_rdata, 16'hF0F0);
    repeat (2) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
